// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 1-bit two-lane mux/demux pair.
package mux_demux_pkg;

    localparam logic LANE0         = 1'b0;
    localparam logic LANE1         = 1'b1;
    localparam int   DEFAULT_DEPTH = 4;

    // One serial beat as it leaves the mux.
    typedef struct packed {
        logic data;
        logic lane;
    } beat_t;

    function automatic logic other_lane(input logic lane);
        return ~lane;
    endfunction

endpackage

// File: rtl/fifo_1bit.sv
// Single-bit-wide circular FIFO; push while full and pop while empty are ignored.
module fifo_1bit
    import mux_demux_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic           din,
    output logic           dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the pre-edge count, so a push into a full FIFO
    // is refused even when a pop frees a slot in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_rr_1bit.sv
// Two-lane to one-lane 1-bit merger: per-lane FIFOs drained round-robin
// onto a registered, lane-tagged serial output with downstream pause.
module mux_rr_1bit
    import mux_demux_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in0,
    input  logic data_in0,
    input  logic valid_in1,
    input  logic data_in1,
    input  logic pause,
    output logic full0,
    output logic full1,
    output logic data_out,
    output logic valid_out,
    output logic lane_out,
    output logic overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic           pop0, pop1;
    logic           dout0, dout1;
    logic           empty0, empty1;
    logic [PTR_W:0] count0, count1;
    logic           last_lane;
    logic           pref;
    beat_t          beat;

    fifo_1bit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (valid_in0),
        .pop   (pop0),
        .din   (data_in0),
        .dout  (dout0),
        .full  (full0),
        .empty (empty0),
        .count (count0)
    );

    fifo_1bit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (valid_in1),
        .pop   (pop1),
        .din   (data_in1),
        .dout  (dout1),
        .full  (full1),
        .empty (empty1),
        .count (count1)
    );

    assign pref = other_lane(last_lane);

    // Preferred lane first; fall back to the other lane so no cycle is wasted.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!pause) begin
            if (pref == LANE0) begin
                if (!empty0)      pop0 = 1'b1;
                else if (!empty1) pop1 = 1'b1;
            end else begin
                if (!empty1)      pop1 = 1'b1;
                else if (!empty0) pop0 = 1'b1;
            end
        end
    end

    always_comb begin
        beat.data = pop1 ? dout1 : dout0;
        beat.lane = pop1 ? LANE1 : LANE0;
    end

    // While paused everything holds, so a valid beat repeats until release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            lane_out  <= LANE0;
            overflow  <= 1'b0;
            last_lane <= LANE1;
        end else begin
            if ((valid_in0 && full0) || (valid_in1 && full1))
                overflow <= 1'b1;
            if (!pause) begin
                valid_out <= pop0 | pop1;
                if (pop0 | pop1) begin
                    data_out  <= beat.data;
                    lane_out  <= beat.lane;
                    last_lane <= beat.lane;
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        (count0 <= FULL_CNT) && (count1 <= FULL_CNT));

endmodule

// File: tb/tb_mux_rr_1bit.sv
// Self-checking bench for mux_rr_1bit: directed tables plus random traffic vs a queue model.
module tb_mux_rr_1bit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic valid_in0 = 1'b0, data_in0 = 1'b0;
    logic valid_in1 = 1'b0, data_in1 = 1'b0;
    logic pause = 1'b0;
    logic full0, full1, data_out, valid_out, lane_out, overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: two plain queues plus the output state.
    bit   q0[$];
    bit   q1[$];
    logic m_data, m_lane, m_valid, m_last, m_ovf;

    typedef struct {
        logic v0, d0, v1, d1, p;
        logic ev, ed, el;
    } vec_t;

    mux_rr_1bit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in0 (valid_in0),
        .data_in0  (data_in0),
        .valid_in1 (valid_in1),
        .data_in1  (data_in1),
        .pause     (pause),
        .full0     (full0),
        .full1     (full1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_data = 0; m_lane = 0; m_valid = 0; m_ovf = 0; m_last = 1;
    endtask

    task automatic model_edge();
        bit f0, f1, b;
        f0 = (q0.size() == DEPTH);
        f1 = (q1.size() == DEPTH);
        if (!pause) begin
            m_valid = 1;
            if (m_last == 1 && q0.size() > 0)      begin b = q0.pop_front(); m_lane = 0; end
            else if (m_last == 0 && q1.size() > 0) begin b = q1.pop_front(); m_lane = 1; end
            else if (q0.size() > 0)                begin b = q0.pop_front(); m_lane = 0; end
            else if (q1.size() > 0)                begin b = q1.pop_front(); m_lane = 1; end
            else m_valid = 0;
            if (m_valid) begin m_data = b; m_last = m_lane; end
        end
        if (valid_in0) begin if (f0) m_ovf = 1; else q0.push_back(data_in0); end
        if (valid_in1) begin if (f1) m_ovf = 1; else q1.push_back(data_in1); end
    endtask

    task automatic step(input logic v0, d0, v1, d1, p);
        @(negedge clk);
        valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1; pause = p;
        chk("full0", full0, q0.size() == DEPTH);
        chk("full1", full1, q1.size() == DEPTH);
        @(posedge clk);
        model_edge();
        #1;
        chk("valid_out", valid_out, m_valid);
        chk("data_out", data_out, m_data);
        chk("lane_out", lane_out, m_lane);
        chk("overflow", overflow, m_ovf);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_data", data_out, 1'b0);
        chk("rst_lane", lane_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_full0", full0, 1'b0);
        chk("rst_full1", full1, 1'b0);
        model_reset();
        @(negedge clk);
        valid_in0 = 0; valid_in1 = 0; pause = 0;
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        logic exp_d[4], exp_l[4], bits[5];
        logic hd, hl, hv;
        int   nbeats;

        model_reset();
        #2 reset = 1'b1;
        #1;
        chk("init_valid", valid_out, 1'b0);
        chk("init_data", data_out, 1'b0);
        chk("init_lane", lane_out, 1'b0);
        chk("init_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("idle_valid", valid_out, 1'b0);
        end

        // Single lane: 1,0,1,1 on lane 0, one-cycle latency.
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 1, 1, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{1, 1, 0, 0, 0, 1, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].p);
            chk("tbl_valid", valid_out, tbl[i].ev);
            chk("tbl_data", data_out, tbl[i].ed);
            chk("tbl_lane", lane_out, tbl[i].el);
        end

        // Alternation after reset: lane 0 must win first.
        do_reset();
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        chk("alt_hold_valid", valid_out, 1'b0);
        exp_d = '{1, 0, 1, 0};
        exp_l = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("alt_valid", valid_out, 1'b1);
            chk("alt_data", data_out, exp_d[i]);
            chk("alt_lane", lane_out, exp_l[i]);
        end
        step(0, 0, 0, 0, 0);
        chk("alt_end_valid", valid_out, 1'b0);

        // Overflow on lane 1 while paused.
        do_reset();
        bits = '{1, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, bits[i], 1);
            if (i == 3) chk("ovf_full1", full1, 1'b1);
            if (i == 3) chk("ovf_not_yet", overflow, 1'b0);
        end
        chk("ovf_set", overflow, 1'b1);
        nbeats = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            if (valid_out === 1'b1) begin
                if (nbeats < 4) chk("ovf_order", data_out, bits[nbeats]);
                nbeats++;
            end
        end
        chk("ovf_beats4", nbeats == 4, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);

        // Pause hold mid-stream.
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        hd = data_out; hl = lane_out; hv = valid_out;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            chk("pz_data", data_out, hd);
            chk("pz_lane", lane_out, hl);
            chk("pz_valid", valid_out, hv);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        chk("pz_drained", valid_out, 1'b0);

        // Async reset mid-stream, then simultaneous push.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
        chk("mid_active", valid_out, 1'b1);
        do_reset();
        step(1, 0, 1, 1, 0);
        chk("mid_lat", valid_out, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("mid_first_valid", valid_out, 1'b1);
        chk("mid_first_lane", lane_out, 1'b0);
        chk("mid_first_data", data_out, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            step(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
